// File: rtl/pipe_sbuf_pkg.sv
// Shared store-size encodings and the store-buffer payload type.
// No logic here; imported by the store buffer and its match slices.
// The dcsz encoding is shared with the pipe's dcache size field.
package pipe_sbuf_pkg;

  localparam logic [2:0] DCSZBYTE  = 3'd0;
  localparam logic [2:0] DCSZHALF  = 3'd1;
  localparam logic [2:0] DCSZWORD  = 3'd3;
  localparam logic [2:0] DCSZDWORD = 3'd7;

  // Everything an entry carries besides its address.
  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  sz;
    logic        cache;
  } sbdat_t;

  function automatic logic sz_legal(input logic [2:0] sz);
    return (sz == DCSZBYTE) || (sz == DCSZHALF) ||
           (sz == DCSZWORD) || (sz == DCSZDWORD);
  endfunction

endpackage

// File: rtl/pipe_sbuf_match.sv
// One store-buffer slot's load-overlap detector (doubleword granularity).
// Latency: purely combinational.
// Backpressure: none; the result feeds the pipe's load-stall decision.
module pipe_sbuf_match #(
  parameter int PAW = 32
) (
  input  logic           vld,
  input  logic [PAW-4:0] epa_dw,
  input  logic [PAW-4:0] ldpa_dw,
  output logic           hit
);

  assign hit = vld && (epa_dw == ldpa_dw);

endmodule

// File: rtl/pipe_sbuf.sv
// Posted in-order store buffer between WB and the dcache write port; flags overlapping loads.
// Latency: a push is visible on dcwrite the next phi2 cycle; no flow-through.
// Backpressure: wfull (registered count only) stops pushes; dcbusy holds the head stable.
module pipe_sbuf
  import pipe_sbuf_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PAW     = 32,
  parameter bit UCORDER = 1'b1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           phi2,
  input  logic           wpush,
  input  logic [PAW-1:0] wpa,
  input  logic [63:0]    wdata,
  input  logic [2:0]     wsz,
  input  logic           wcache,
  output logic           wfull,
  output logic           sbempty,
  output logic           sbovf,
  input  logic           ldreq,
  input  logic [PAW-1:0] ldpa,
  input  logic           ldcache,
  output logic           ldconf,
  output logic           dcwrite,
  output logic [PAW-1:0] dcpa,
  output logic [63:0]    dcwdata,
  output logic [2:0]     dcsz,
  output logic           dccache,
  input  logic           dcbusy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULLCNT = {1'b1, {AW{1'b0}}};

  logic [PAW-1:0] pa_q  [DEPTH];
  sbdat_t         dat_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]  rd_q;
  logic [AW-1:0]  wr_q;
  logic [AW:0]    count_q;
  logic           sbovf_q;

  logic push;
  logic pop;
  logic drop;
  logic [DEPTH-1:0] hit;
  logic wr_hit;
  logic uc_hit;
  logic ld_unused;

  assign wfull   = (count_q == FULLCNT);
  assign sbempty = (count_q == '0);
  assign sbovf   = sbovf_q;
  assign dcwrite = valid_q[rd_q];

  // A push against a full buffer is dropped even if the head pops this cycle.
  assign push = phi2 && wpush && !wfull;
  assign drop = phi2 && wpush && wfull;
  assign pop  = phi2 && dcwrite && !dcbusy;

  assign dcpa    = pa_q[rd_q];
  assign dcwdata = dat_q[rd_q].data;
  assign dcsz    = dat_q[rd_q].sz;
  assign dccache = dat_q[rd_q].cache;

  // Entry payload: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pa_q[wr_q]  <= wpa;
      dat_q[wr_q] <= '{data: wdata, sz: wsz, cache: wcache};
    end
  end

  // Pointers, occupancy, valid bits and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      valid_q <= '0;
      sbovf_q <= 1'b0;
    end else begin
      if (push) begin
        valid_q[wr_q] <= 1'b1;
        wr_q          <= wr_q + AW'(1);
      end
      if (pop) begin
        valid_q[rd_q] <= 1'b0;
        rd_q          <= rd_q + AW'(1);
      end
      if (drop) begin
        sbovf_q <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    pipe_sbuf_match #(.PAW(PAW)) u_match (
      .vld     (valid_q[i]),
      .epa_dw  (pa_q[i][PAW-1:3]),
      .ldpa_dw (ldpa[PAW-1:3]),
      .hit     (hit[i])
    );
  end

  // The store being pushed right now is not yet in the array but still blocks the load.
  assign wr_hit = wpush && (wpa[PAW-1:3] == ldpa[PAW-1:3]);
  // Uncached loads wait for every older store so I/O side effects stay ordered.
  assign uc_hit = UCORDER && !ldcache && (!sbempty || wpush);
  assign ldconf = ldreq && ((|hit) || wr_hit || uc_hit);

  // Byte offset of the load does not matter at doubleword granularity.
  assign ld_unused = &{1'b0, ldpa[2:0]};

endmodule

// File: tb/tb_pipe_sbuf.sv
module tb_pipe_sbuf;
  import pipe_sbuf_pkg::*;

  logic        clk;
  logic        resetn, phi2, wpush, wcache, ldreq, ldcache, dcbusy;
  logic [31:0] wpa, ldpa;
  logic [63:0] wdata;
  logic [2:0]  wsz;

  logic        wfull_a [4];
  logic        sbempty_a [4];
  logic        sbovf_a [4];
  logic        ldconf_a [4];
  logic        dcwrite_a [4];
  logic [31:0] dcpa_a [4];
  logic [63:0] dcwdata_a [4];
  logic [2:0]  dcsz_a [4];
  logic        dccache_a [4];

  // Instance configurations: 0 = D4/UC1, 1 = D2/UC1, 2 = D8/UC1, 3 = D4/UC0
  int depth_of [4] = '{4, 2, 8, 4};
  bit uc_of    [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  pipe_sbuf #(.DEPTH(4), .PAW(32), .UCORDER(1'b1)) u_d4 (
    .clk(clk), .resetn(resetn), .phi2(phi2), .wpush(wpush), .wpa(wpa), .wdata(wdata),
    .wsz(wsz), .wcache(wcache), .wfull(wfull_a[0]), .sbempty(sbempty_a[0]), .sbovf(sbovf_a[0]),
    .ldreq(ldreq), .ldpa(ldpa), .ldcache(ldcache), .ldconf(ldconf_a[0]), .dcwrite(dcwrite_a[0]),
    .dcpa(dcpa_a[0]), .dcwdata(dcwdata_a[0]), .dcsz(dcsz_a[0]), .dccache(dccache_a[0]), .dcbusy(dcbusy));
  pipe_sbuf #(.DEPTH(2), .PAW(32), .UCORDER(1'b1)) u_d2 (
    .clk(clk), .resetn(resetn), .phi2(phi2), .wpush(wpush), .wpa(wpa), .wdata(wdata),
    .wsz(wsz), .wcache(wcache), .wfull(wfull_a[1]), .sbempty(sbempty_a[1]), .sbovf(sbovf_a[1]),
    .ldreq(ldreq), .ldpa(ldpa), .ldcache(ldcache), .ldconf(ldconf_a[1]), .dcwrite(dcwrite_a[1]),
    .dcpa(dcpa_a[1]), .dcwdata(dcwdata_a[1]), .dcsz(dcsz_a[1]), .dccache(dccache_a[1]), .dcbusy(dcbusy));
  pipe_sbuf #(.DEPTH(8), .PAW(32), .UCORDER(1'b1)) u_d8 (
    .clk(clk), .resetn(resetn), .phi2(phi2), .wpush(wpush), .wpa(wpa), .wdata(wdata),
    .wsz(wsz), .wcache(wcache), .wfull(wfull_a[2]), .sbempty(sbempty_a[2]), .sbovf(sbovf_a[2]),
    .ldreq(ldreq), .ldpa(ldpa), .ldcache(ldcache), .ldconf(ldconf_a[2]), .dcwrite(dcwrite_a[2]),
    .dcpa(dcpa_a[2]), .dcwdata(dcwdata_a[2]), .dcsz(dcsz_a[2]), .dccache(dccache_a[2]), .dcbusy(dcbusy));
  pipe_sbuf #(.DEPTH(4), .PAW(32), .UCORDER(1'b0)) u_d4u0 (
    .clk(clk), .resetn(resetn), .phi2(phi2), .wpush(wpush), .wpa(wpa), .wdata(wdata),
    .wsz(wsz), .wcache(wcache), .wfull(wfull_a[3]), .sbempty(sbempty_a[3]), .sbovf(sbovf_a[3]),
    .ldreq(ldreq), .ldpa(ldpa), .ldcache(ldcache), .ldconf(ldconf_a[3]), .dcwrite(dcwrite_a[3]),
    .dcpa(dcpa_a[3]), .dcwdata(dcwdata_a[3]), .dcsz(dcsz_a[3]), .dccache(dccache_a[3]), .dcbusy(dcbusy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each buffer is an ordered list of posted stores
  typedef struct packed {
    logic [31:0] pa;
    logic [63:0] data;
    logic [2:0]  sz;
    logic        cache;
  } st_t;

  st_t mq [4][$];
  bit  movf [4];
  bit  armed = 1'b0;
  int  ncmp = 0;
  int  nbad = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s inst%0d at %0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  function automatic bit exp_ldconf(input int k);
    bit any = 1'b0;
    for (int j = 0; j < mq[k].size(); j++)
      if ((mq[k][j].pa >> 3) == (ldpa >> 3)) any = 1'b1;
    if (wpush && ((wpa >> 3) == (ldpa >> 3))) any = 1'b1;
    if (uc_of[k] && !ldcache && (mq[k].size() != 0 || wpush)) any = 1'b1;
    return ldreq && any;
  endfunction

  // Every negedge: compare all outputs against the model, then advance the model
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 4; k++) begin
        int n;
        n = mq[k].size();
        chk("wfull",   k, 64'(wfull_a[k]),   64'(n == depth_of[k]));
        chk("sbempty", k, 64'(sbempty_a[k]), 64'(n == 0));
        chk("sbovf",   k, 64'(sbovf_a[k]),   64'(movf[k]));
        chk("dcwrite", k, 64'(dcwrite_a[k]), 64'(n != 0));
        chk("ldconf",  k, 64'(ldconf_a[k]),  64'(exp_ldconf(k)));
        if (n != 0) begin
          chk("dcpa",    k, 64'(dcpa_a[k]),    64'(mq[k][0].pa));
          chk("dcwdata", k, dcwdata_a[k],      mq[k][0].data);
          chk("dcsz",    k, 64'(dcsz_a[k]),    64'(mq[k][0].sz));
          chk("dccache", k, 64'(dccache_a[k]), 64'(mq[k][0].cache));
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (!resetn) begin
        mq[k].delete();
        movf[k] = 1'b0;
      end else if (phi2) begin
        bit full;
        full = (mq[k].size() == depth_of[k]);
        if (wpush && full) movf[k] = 1'b1;
        if (mq[k].size() != 0 && !dcbusy) void'(mq[k].pop_front());
        if (wpush && !full) mq[k].push_back('{pa: wpa, data: wdata, sz: wsz, cache: wcache});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] pa, input logic [63:0] d, input logic [2:0] sz, input logic c);
    wpush = 1'b1; wpa = pa; wdata = d; wsz = sz; wcache = c;
  endtask

  logic [2:0] sz_tab [4] = '{DCSZBYTE, DCSZHALF, DCSZWORD, DCSZDWORD};

  initial begin
    resetn = 1'b0; phi2 = 1'b1; wpush = 1'b0; wpa = '0; wdata = '0; wsz = '0; wcache = 1'b0;
    ldreq = 1'b0; ldpa = '0; ldcache = 1'b1; dcbusy = 1'b0;
    tick(); tick();
    armed = 1'b1;
    resetn = 1'b1;
    chk("rst_dcwrite", 0, 64'(dcwrite_a[0]), 64'd0);
    chk("rst_wfull",   0, 64'(wfull_a[0]),   64'd0);
    chk("rst_sbempty", 0, 64'(sbempty_a[0]), 64'd1);
    chk("rst_sbovf",   0, 64'(sbovf_a[0]),   64'd0);
    chk("rst_ldconf",  0, 64'(ldconf_a[0]),  64'd0);

    // 1: four back-to-back stores drain one per cycle in order
    for (int i = 0; i < 4; i++) begin
      put(32'h100 + 32'(8 * i), 64'hA0 + 64'(i), DCSZDWORD, 1'b1);
      tick();
      chk("t1_dcpa",    0, 64'(dcpa_a[0]), 64'h100 + 64'(8 * i));
      chk("t1_dcwdata", 0, dcwdata_a[0],   64'hA0 + 64'(i));
    end
    wpush = 1'b0;
    tick();
    chk("t1_empty", 0, 64'(sbempty_a[0]), 64'd1);

    // 2: fill while dcache busy, fifth store dropped, then exactly four writes
    dcbusy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put(32'h200 + 32'(8 * i), 64'hB0 + 64'(i), DCSZWORD, 1'b1);
      tick();
      chk("t2_wfull", 0, 64'(wfull_a[0]), (i >= 3) ? 64'd1 : 64'd0);
      chk("t2_sbovf", 0, 64'(sbovf_a[0]), (i == 4) ? 64'd1 : 64'd0);
    end
    wpush = 1'b0; dcbusy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_dcpa", 0, 64'(dcpa_a[0]), 64'h200 + 64'(8 * i));
      tick();
    end
    chk("t2_empty", 0, 64'(sbempty_a[0]), 64'd1);

    // 3: doubleword overlap detection
    resetn = 1'b0; tick(); resetn = 1'b1;
    chk("t3_ovfclr", 0, 64'(sbovf_a[0]), 64'd0);
    dcbusy = 1'b1;
    put(32'h2008, 64'hC0, DCSZWORD, 1'b1);
    tick();
    wpush = 1'b0; ldreq = 1'b1; ldpa = 32'h200C; ldcache = 1'b1;
    #1 chk("t3_conf", 0, 64'(ldconf_a[0]), 64'd1);
    ldpa = 32'h2010;
    #1 chk("t3_noconf", 0, 64'(ldconf_a[0]), 64'd0);
    ldpa = 32'h200C; dcbusy = 1'b0;
    tick();
    chk("t3_drained", 0, 64'(ldconf_a[0]), 64'd0);
    ldreq = 1'b0;

    // 4: uncached load ordering, on and off
    dcbusy = 1'b1;
    put(32'h40, 64'hD0, DCSZBYTE, 1'b1);
    tick();
    wpush = 1'b0; ldreq = 1'b1; ldpa = 32'hA000_0000; ldcache = 1'b0;
    #1 chk("t4_uc1", 0, 64'(ldconf_a[0]), 64'd1);
    chk("t4_uc0", 3, 64'(ldconf_a[3]), 64'd0);
    dcbusy = 1'b0;
    tick();
    chk("t4_empty", 0, 64'(sbempty_a[0]), 64'd1);
    chk("t4_uc1_clr", 0, 64'(ldconf_a[0]), 64'd0);
    ldreq = 1'b0; ldcache = 1'b1;

    // 5: push and pop at count one, then head held under dcbusy
    dcbusy = 1'b1;
    put(32'h300, 64'h11, DCSZHALF, 1'b0);
    tick();
    dcbusy = 1'b0;
    put(32'h308, 64'h22, DCSZDWORD, 1'b1);
    tick();
    wpush = 1'b0; dcbusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_dcpa",    0, 64'(dcpa_a[0]),    64'h308);
      chk("t5_dcwdata", 0, dcwdata_a[0],      64'h22);
      chk("t5_nonempty",0, 64'(sbempty_a[0]), 64'd0);
      tick();
    end
    dcbusy = 1'b0;
    tick();
    chk("t5_empty", 0, 64'(sbempty_a[0]), 64'd1);

    // 6: reset discards buffered stores mid-drain
    dcbusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(32'h400 + 32'(8 * i), 64'hE0 + 64'(i), DCSZWORD, 1'b1);
      tick();
    end
    wpush = 1'b0;
    chk("t6_pre", 0, 64'(dcwrite_a[0]), 64'd1);
    resetn = 1'b0;
    tick();
    chk("t6_dcwrite", 0, 64'(dcwrite_a[0]), 64'd0);
    chk("t6_empty",   0, 64'(sbempty_a[0]), 64'd1);
    resetn = 1'b1; dcbusy = 1'b0;
    tick();
    chk("t6_nowrite", 0, 64'(dcwrite_a[0]), 64'd0);

    // Randomized traffic across all configurations
    for (int c = 0; c < 4000; c++) begin
      phi2    = ($urandom_range(0, 9) != 0);
      resetn  = ($urandom_range(0, 299) != 0);
      if (!resetn) phi2 = 1'b1;
      wpush   = ($urandom_range(0, 1) == 1);
      wpa     = 32'h1000 + 32'($urandom_range(0, 15) << 3) + 32'($urandom_range(0, 7));
      wdata   = {$urandom, $urandom};
      wsz     = sz_tab[$urandom_range(0, 3)];
      wcache  = ($urandom_range(0, 3) != 0);
      ldreq   = ($urandom_range(0, 1) == 1);
      ldpa    = ($urandom_range(0, 7) == 0) ? 32'hA000_0000
              : 32'h1000 + 32'($urandom_range(0, 15) << 3) + 32'($urandom_range(0, 7));
      ldcache = ($urandom_range(0, 3) != 0);
      dcbusy  = ($urandom_range(0, 9) < 4);
      tick();
    end
    wpush = 1'b0; ldreq = 1'b0; resetn = 1'b1; phi2 = 1'b1; dcbusy = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    for (int k = 0; k < 4; k++) chk("final_empty", k, 64'(sbempty_a[k]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
